im_boot_loader: RTL and testbench
=================================

# im_boot_loader

Parametrised program loader between an external word stream (host, UART bridge or bench) and the CPU top-level instruction-memory write port (`i_we`, `IM_addr`, `i_dataout`). It holds the CPU in reset, writes N instruction words into IM at sequential addresses from a programmable base, keeps a running checksum, then releases reset and pulses `start`. It generalises the fixed 8-bit/16-bit IM preload sequence with a valid/ready stream, configurable widths, abort and status reporting.

## Interface
- `DATA_W`, 16, instruction word width.
- `ADDR_W`, 8, IM address width.
- `RST_CYCLES`, 2, cycles `cpu_reset` is held low before the first write (≥1).
- `GAP`, 1, cycles between `cpu_reset` release and `start` (≥1).
- `START_W`, 1, `start` pulse width in cycles (≥1).

Ports:
- `clock` in 1, sole clock, rising edge.
- `reset` in 1, asynchronous, active-low; block reset.
- `load_req` in 1, begin a load session (sampled in IDLE only).
- `base_addr` in ADDR_W, first IM address; captured on accepted `load_req`.
- `word_count` in ADDR_W+1, words to load, 0..2^ADDR_W; captured with `base_addr`.
- `abort` in 1, cancel a session in progress.
- `s_valid` in 1 / `s_data` in DATA_W / `s_ready` out 1, input word stream.
- `i_we` out 1, IM write enable.
- `IM_addr` out ADDR_W, IM write address.
- `i_dataout` out DATA_W, IM write data.
- `cpu_reset` out 1, active-low CPU reset.
- `cpu_enable` out 1, CPU enable.
- `start` out 1, CPU start pulse.
- `busy` out 1, session in progress.
- `done` out 1, sticky; last session completed.
- `error` out 1, sticky; last session aborted.
- `checksum` out DATA_W, sum of all words written this session, mod 2^DATA_W.

## Operation
- All outputs are registered. Reset values: `i_we`=0, `IM_addr`=0, `i_dataout`=0, `cpu_reset`=0 (CPU held), `cpu_enable`=0, `start`=0, `s_ready`=0, `busy`=0, `done`=0, `error`=0, `checksum`=0. State = IDLE.
- IDLE: `load_req`=1 captures `base_addr` and `word_count`, clears `done`, `error` and `checksum`, sets `busy`, drives `cpu_reset`=0 and `cpu_enable`=0, and enters HOLD.
- HOLD: counts RST_CYCLES, then enters LOAD. If `word_count`=0, goes directly to RELEASE.
- LOAD: `s_ready`=1 while remaining>0. Each handshake (`s_valid` & `s_ready`) writes IM on the next cycle: `i_we`=1, `IM_addr`=current address, `i_dataout`=`s_data`, `checksum` += `s_data`. The address then increments, and remaining decrements. When the last word is accepted, `s_ready` drops the next cycle and the state moves to RELEASE. `i_we`=0 on every cycle without a handshake in the previous cycle.
- Address arithmetic is modulo 2^ADDR_W. Wrap-around from 2^ADDR_W−1 to 0 is legal and is not an error.
- RELEASE: `cpu_reset`=1 and `cpu_enable`=1; counts GAP cycles, then enters START.
- START: `start`=1 for START_W cycles, then enters DONE.
- DONE: sets `done`=1, clears `busy`, returns to IDLE. `cpu_reset`, `cpu_enable` and `checksum` hold their values until the next session.
- `abort`=1 in HOLD or LOAD: the next state is IDLE. `error`=1, `busy`=0, `s_ready`=0, `i_we`=0. `cpu_reset` stays 0. A word handshaken in the same cycle as `abort` is not written.
- `abort` in RELEASE, START, DONE or IDLE is ignored.
- `load_req` outside IDLE is ignored. `load_req` and `abort` together in IDLE: the load starts.
- `reset` asserted mid-session returns every output to its reset value at once, with no partial write completion.

## Timing
- `load_req` at cycle 0 → `busy` and HOLD from cycle 1; LOAD from cycle 1+RST_CYCLES.
- Handshake at cycle k → `i_we`/`IM_addr`/`i_dataout` valid in cycle k+1; `checksum` updated at cycle k+1.
- One word per cycle maximum throughput. `s_valid` gaps stall without penalty.
- Last handshake at cycle L → RELEASE at L+1; `start` high from L+1+GAP for START_W cycles; `done` at L+1+GAP+START_W.
- `word_count`=0: RELEASE at 1+RST_CYCLES. No `i_we` pulse.

## Test plan
- Defaults; base=0, count=13, 13 words streamed back-to-back → 13 `i_we` pulses at addresses 0..12 with matching data; `checksum` = 16-bit sum; `start` one cycle, 1 cycle after `cpu_reset` rises; `done`=1.
- `s_valid` toggling 1/0 every cycle, count=4 → writes only on cycles after handshakes; `s_ready` drops after the 4th word; no 5th write.
- base=8'hFE, count=4 → `IM_addr` sequence FE, FF, 00, 01; `error`=0.
- count=0 → no `i_we`; `cpu_reset` rises at cycle 1+RST_CYCLES; `start` pulse follows; `done`=1, `checksum`=0.
- `abort` on the 3rd handshake cycle of count=8 → only 2 writes; `error`=1, `busy`=0, `cpu_reset` stays 0, `start` never asserted.
- `reset` low during LOAD → all outputs at reset values on the same edge; a new `load_req` afterwards completes normally.

Source files
------------

// File: rtl/im_boot_loader.sv
// Instruction-memory boot loader: holds the CPU in reset, streams word_count words into IM
// from base_addr, accumulates a checksum, then releases reset and pulses start.
// Latency: handshake at cycle k -> IM write at k+1; load_req at 0 -> LOAD at 1+RST_CYCLES.
// Backpressure: s_ready is high only in LOAD while words remain; s_valid gaps stall freely.
//
// Ports:
//   clock, reset (async, active-low)
//   load_req, base_addr, word_count, abort : session control (load_req sampled in IDLE only)
//   s_valid / s_data / s_ready             : input word stream
//   i_we, IM_addr, i_dataout               : IM write port
//   cpu_reset (active-low), cpu_enable, start : CPU control
//   busy, done (sticky), error (sticky), checksum : status
module im_boot_loader #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 8,
  parameter int RST_CYCLES = 2,
  parameter int GAP        = 1,
  parameter int START_W    = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_req,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  input  logic              abort,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              i_we,
  output logic [ADDR_W-1:0] IM_addr,
  output logic [DATA_W-1:0] i_dataout,
  output logic              cpu_reset,
  output logic              cpu_enable,
  output logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [DATA_W-1:0] checksum
);

  // One shared phase counter serves HOLD, RELEASE and START; size it for the longest.
  localparam int MAX_CNT = (RST_CYCLES > GAP) ?
                           ((RST_CYCLES > START_W) ? RST_CYCLES : START_W) :
                           ((GAP > START_W) ? GAP : START_W);
  localparam int CNT_W = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP - 1);
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD,
    S_LOAD,
    S_RELEASE,
    S_START,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;       // next IM address to write
  logic [ADDR_W:0]     rem_q, rem_d;         // words still to accept
  logic                s_ready_q, s_ready_d;
  logic                i_we_q, i_we_d;
  logic [ADDR_W-1:0]   im_addr_q, im_addr_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                cpu_reset_q, cpu_reset_d;
  logic                cpu_enable_q, cpu_enable_d;
  logic                start_q, start_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic [DATA_W-1:0]   csum_q, csum_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      rem_q        <= '0;
      s_ready_q    <= 1'b0;
      i_we_q       <= 1'b0;
      im_addr_q    <= '0;
      dout_q       <= '0;
      cpu_reset_q  <= 1'b0;
      cpu_enable_q <= 1'b0;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      csum_q       <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      rem_q        <= rem_d;
      s_ready_q    <= s_ready_d;
      i_we_q       <= i_we_d;
      im_addr_q    <= im_addr_d;
      dout_q       <= dout_d;
      cpu_reset_q  <= cpu_reset_d;
      cpu_enable_q <= cpu_enable_d;
      start_q      <= start_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      csum_q       <= csum_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    rem_d        = rem_q;
    s_ready_d    = s_ready_q;
    i_we_d       = 1'b0;            // write strobe is a single-cycle pulse
    im_addr_d    = im_addr_q;
    dout_d       = dout_q;
    cpu_reset_d  = cpu_reset_q;
    cpu_enable_d = cpu_enable_q;
    start_d      = start_q;
    busy_d       = busy_q;
    done_d       = done_q;
    error_d      = error_q;
    csum_d       = csum_q;

    unique case (state_q)
      S_IDLE: begin
        // load_req wins over a simultaneous abort here: abort has nothing to cancel yet.
        if (load_req) begin
          addr_d       = base_addr;
          rem_d        = word_count;
          done_d       = 1'b0;
          error_d      = 1'b0;
          csum_d       = '0;
          busy_d       = 1'b1;
          cpu_reset_d  = 1'b0;
          cpu_enable_d = 1'b0;
          cnt_d        = '0;
          state_d      = S_HOLD;
        end
      end

      S_HOLD: begin
        if (abort) begin
          error_d   = 1'b1;
          busy_d    = 1'b0;
          s_ready_d = 1'b0;
          state_d   = S_IDLE;
        end else if (cnt_q == HOLD_LAST) begin
          cnt_d = '0;
          if (rem_q == '0) begin
            cpu_reset_d  = 1'b1;
            cpu_enable_d = 1'b1;
            state_d      = S_RELEASE;
          end else begin
            s_ready_d = 1'b1;
            state_d   = S_LOAD;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_LOAD: begin
        // Abort has priority: a word accepted on the abort cycle is dropped.
        if (abort) begin
          error_d   = 1'b1;
          busy_d    = 1'b0;
          s_ready_d = 1'b0;
          state_d   = S_IDLE;
        end else if (s_valid && s_ready_q) begin
          i_we_d    = 1'b1;
          im_addr_d = addr_q;
          dout_d    = s_data;
          csum_d    = csum_q + s_data;
          addr_d    = addr_q + ADDR_W'(1);   // wraps modulo 2^ADDR_W
          rem_d     = rem_q - (ADDR_W + 1)'(1);
          if (rem_q == (ADDR_W + 1)'(1)) begin
            s_ready_d    = 1'b0;
            cpu_reset_d  = 1'b1;
            cpu_enable_d = 1'b1;
            cnt_d        = '0;
            state_d      = S_RELEASE;
          end
        end
      end

      S_RELEASE: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          start_d = 1'b1;
          state_d = S_START;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_START: begin
        if (cnt_q == START_LAST) begin
          cnt_d   = '0;
          start_d = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign s_ready    = s_ready_q;
  assign i_we       = i_we_q;
  assign IM_addr    = im_addr_q;
  assign i_dataout  = dout_q;
  assign cpu_reset  = cpu_reset_q;
  assign cpu_enable = cpu_enable_q;
  assign start      = start_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign checksum   = csum_q;

endmodule

// File: tb/tb_im_boot_loader.sv
// Directed bench for im_boot_loader with default parameters.
// Cycle numbers below are relative to the cycle in which load_req is high (cycle 0).
// Inputs change on the falling edge; a monitor samples outputs 2 ns after each rising edge.
module tb_im_boot_loader;
  localparam int DW = 16;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_req = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   word_count = '0;
  logic          abort = 1'b0;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready, i_we, cpu_reset, cpu_enable, start, busy, done, error;
  logic [AW-1:0] im_addr;
  logic [DW-1:0] i_dataout, checksum;

  im_boot_loader dut (
    .clock      (clk),
    .reset      (rst_n),
    .load_req   (load_req),
    .base_addr  (base_addr),
    .word_count (word_count),
    .abort      (abort),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .i_we       (i_we),
    .IM_addr    (im_addr),
    .i_dataout  (i_dataout),
    .cpu_reset  (cpu_reset),
    .cpu_enable (cpu_enable),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .checksum   (checksum)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int c0 = 0;

  int wr_addr[$];
  int wr_data[$];
  int wr_cyc[$];
  int rst_rise = -1;
  int start_rise = -1;
  int done_rise = -1;
  int start_hi = 0;
  logic p_rst = 1'b0, p_start = 1'b0, p_done = 1'b0;

  // Output monitor: logs every IM write and the rising edges of the CPU control lines.
  always @(posedge clk) begin
    #2;
    cyc = cyc + 1;
    if (i_we) begin
      wr_addr.push_back(int'(im_addr));
      wr_data.push_back(int'(i_dataout));
      wr_cyc.push_back(cyc);
    end
    if (cpu_reset && !p_rst) rst_rise = cyc;
    if (start && !p_start) start_rise = cyc;
    if (start) start_hi = start_hi + 1;
    if (done && !p_done) done_rise = cyc;
    p_rst = cpu_reset;
    p_start = start;
    p_done = done;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_load(input int b, input int n, input bit with_abort);
    @(negedge clk);
    load_req   = 1'b1;
    base_addr  = AW'(b);
    word_count = (AW + 1)'(n);
    abort      = with_abort;
    c0         = cyc;
    @(negedge clk);
    load_req = 1'b0;
    abort    = 1'b0;
  endtask

  // Drives n words dbase+i. toggle: s_valid alternates 1/0. abort_at: word index whose
  // handshake cycle also raises abort (-1 = none). extra: cycles of junk s_valid afterwards.
  task automatic stream(input string tag, input int n, input int dbase, input bit toggle,
                        input int abort_at, input int extra);
    int  idx = 0;
    int  budget = 0;
    int  extra_left = extra;
    bit  ph = 1'b1;
    bit  fed = 1'b0;
    bit  finished = 1'b0;
    while (!finished && budget < 100) begin
      @(negedge clk);
      budget++;
      abort = 1'b0;
      if (fed) begin
        if (extra_left > 0) begin
          s_valid = 1'b1;
          s_data  = 16'hDEAD;
          extra_left--;
        end else begin
          s_valid  = 1'b0;
          finished = 1'b1;
        end
      end else if (toggle && !ph) begin
        s_valid = 1'b0;
      end else begin
        s_valid = 1'b1;
        s_data  = DW'(dbase + idx);
        if (s_ready) begin
          if (idx == abort_at) begin
            abort      = 1'b1;
            fed        = 1'b1;
            extra_left = 0;
          end else begin
            idx++;
            if (idx == n) fed = 1'b1;
          end
        end
      end
      ph = !ph;
    end
    chk({tag, "_stream_end"}, finished, 1);
  endtask

  task automatic wait_done(input string tag);
    int b = 0;
    while (!done && b < 60) begin
      @(negedge clk);
      b++;
    end
    chk({tag, "_done"}, done, 1);
  endtask

  task automatic check_writes(input string tag, input int w0, input int n, input int abase,
                              input int dbase, input int first, input int step);
    int got;
    got = wr_addr.size() - w0;
    chk({tag, "_nwrites"}, got, n);
    for (int i = 0; i < n && i < got; i++) begin
      chk({tag, "_addr"}, wr_addr[w0 + i], (abase + i) % 256);
      chk({tag, "_data"}, wr_data[w0 + i], dbase + i);
      chk({tag, "_wcyc"}, wr_cyc[w0 + i] - c0, first + step * i);
    end
  endtask

  int w0;
  int s0;

  initial begin
    // ---------------- reset state ----------------
    repeat (2) @(negedge clk);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_i_we", i_we, 0);
    chk("rst_IM_addr", im_addr, 0);
    chk("rst_i_dataout", i_dataout, 0);
    chk("rst_cpu_reset", cpu_reset, 0);
    chk("rst_cpu_enable", cpu_enable, 0);
    chk("rst_start", start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_checksum", checksum, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // ---------------- T1: base 0, 13 words back-to-back ----------------
    w0 = wr_addr.size();
    s0 = start_hi;
    start_load(0, 13, 1'b0);
    chk("t1_busy_c1", busy, 1);
    chk("t1_ready_c1", s_ready, 0);
    stream("t1", 13, 16'hF000, 1'b0, -1, 0);
    wait_done("t1");
    check_writes("t1", w0, 13, 0, 16'hF000, 4, 1);
    chk("t1_checksum", checksum, 16'h304E);      // 13*F000 + 78 mod 2^16
    chk("t1_rst_rise", rst_rise - c0, 16);
    chk("t1_start_rise", start_rise - c0, 17);
    chk("t1_start_width", start_hi - s0, 1);
    chk("t1_done_rise", done_rise - c0, 18);
    chk("t1_error", error, 0);
    chk("t1_busy_end", busy, 0);
    chk("t1_cpu_enable", cpu_enable, 1);

    // ---------------- T2: s_valid toggling, count 4, junk after ----------------
    w0 = wr_addr.size();
    start_load(8'h20, 4, 1'b0);
    stream("t2", 4, 16'h0100, 1'b1, -1, 3);
    wait_done("t2");
    check_writes("t2", w0, 4, 8'h20, 16'h0100, 5, 2);
    chk("t2_ready_end", s_ready, 0);
    chk("t2_checksum", checksum, 16'h0406);
    chk("t2_rst_rise", rst_rise - c0, 11);

    // ---------------- T3: address wrap FE,FF,00,01 ----------------
    w0 = wr_addr.size();
    start_load(8'hFE, 4, 1'b0);
    stream("t3", 4, 16'h8000, 1'b0, -1, 0);
    wait_done("t3");
    check_writes("t3", w0, 4, 8'hFE, 16'h8000, 4, 1);
    chk("t3_checksum", checksum, 16'h0006);
    chk("t3_error", error, 0);

    // ---------------- T4: count 0, load_req together with abort ----------------
    w0 = wr_addr.size();
    s0 = start_hi;
    start_load(8'h33, 0, 1'b1);
    chk("t4_busy_c1", busy, 1);
    chk("t4_cpu_reset_c1", cpu_reset, 0);
    chk("t4_checksum_clr", checksum, 0);
    wait_done("t4");
    chk("t4_nwrites", wr_addr.size() - w0, 0);
    chk("t4_rst_rise", rst_rise - c0, 3);
    chk("t4_start_rise", start_rise - c0, 4);
    chk("t4_start_width", start_hi - s0, 1);
    chk("t4_done_rise", done_rise - c0, 5);
    chk("t4_error", error, 0);

    // ---------------- T5: abort on 3rd handshake of count 8 ----------------
    w0 = wr_addr.size();
    s0 = start_hi;
    start_load(8'h40, 8, 1'b0);
    stream("t5", 8, 16'h0010, 1'b0, 2, 0);
    chk("t5_error", error, 1);
    chk("t5_busy", busy, 0);
    chk("t5_ready", s_ready, 0);
    chk("t5_i_we", i_we, 0);
    chk("t5_cpu_reset", cpu_reset, 0);
    repeat (5) @(negedge clk);
    check_writes("t5", w0, 2, 8'h40, 16'h0010, 4, 1);
    chk("t5_checksum", checksum, 16'h0021);
    chk("t5_no_start", start_hi - s0, 0);
    chk("t5_done", done, 0);
    chk("t5_cpu_reset_late", cpu_reset, 0);
    chk("t5_cpu_enable", cpu_enable, 0);

    // ---------------- T6: reset mid-LOAD, then a clean session ----------------
    start_load(8'h80, 6, 1'b0);
    stream("t6a", 2, 16'h0100, 1'b0, -1, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_s_ready", s_ready, 0);
    chk("t6_rst_i_we", i_we, 0);
    chk("t6_rst_IM_addr", im_addr, 0);
    chk("t6_rst_i_dataout", i_dataout, 0);
    chk("t6_rst_cpu_reset", cpu_reset, 0);
    chk("t6_rst_cpu_enable", cpu_enable, 0);
    chk("t6_rst_start", start, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_done", done, 0);
    chk("t6_rst_error", error, 0);
    chk("t6_rst_checksum", checksum, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    w0 = wr_addr.size();
    s0 = start_hi;
    start_load(8'h10, 3, 1'b0);
    stream("t6b", 3, 16'h0005, 1'b0, -1, 0);
    wait_done("t6b");
    check_writes("t6b", w0, 3, 8'h10, 16'h0005, 4, 1);
    chk("t6_checksum", checksum, 16'h0012);
    chk("t6_start_width", start_hi - s0, 1);
    chk("t6_error", error, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
